// File: rtl/modcounter_rpt.sv
// rtl/modcounter_rpt.sv - modulo up/down counter with clamped load, wrap/saturate and press-and-hold auto-repeat
//
// Purpose:
//   Range-limited counter (MIN..MAX) for time-setting digits. A button press
//   steps once immediately. Holding the button for HOLD_TICKS timebase ticks
//   starts auto-repeat, which then steps every RPT_TICKS ticks. carry/borrow
//   pulse on wrap so several counters can be chained.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   en        in   step enable (does not gate load)
//   inc       in   up button level (debounced)
//   dec       in   down button level (debounced)
//   tick      in   one-cycle timebase strobe for hold/repeat timing
//   load      in   synchronous load request, clamped into MIN..MAX
//   load_val  in   value to load [B-1:0]
//   cnt       out  registered count [B-1:0]
//   carry     out  one-cycle pulse while cnt shows an up-wrapped value
//   borrow    out  one-cycle pulse while cnt shows a down-wrapped value

module modcounter_rpt #(
    parameter int MIN        = 0,
    parameter int MAX        = 12,
    parameter int B          = $clog2(MAX + 1),
    parameter int SAT        = 0,
    parameter int HOLD_TICKS = 8,
    parameter int RPT_TICKS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    input  logic         tick,
    input  logic         load,
    input  logic [B-1:0] load_val,
    output logic [B-1:0] cnt,
    output logic         carry,
    output logic         borrow
);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    // The tick counter only ever has to reach the larger of the two limits.
    localparam int TMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_TICKS);
    localparam logic [TW-1:0] RPT_T  = TW'(RPT_TICKS);

    // Range bounds: B-bit copies for assignment, B+1-bit copies for compares
    // so that out-of-range load values and the range ends never alias.
    localparam logic [B-1:0] MIN_B = B'(MIN);
    localparam logic [B-1:0] MAX_B = B'(MAX);
    localparam logic [B:0]   MIN_W = (B + 1)'(MIN);
    localparam logic [B:0]   MAX_W = (B + 1)'(MAX);

    state_e        state_q,   state_d;
    dir_e          lastdir_q, lastdir_d;
    logic [TW-1:0] tcnt_q,    tcnt_d;
    logic [B-1:0]  cnt_q,     cnt_d;
    logic          carry_q,   carry_d;
    logic          borrow_q,  borrow_d;

    dir_e          dir;
    logic [TW-1:0] tcnt_inc;
    logic [TW-1:0] tick_limit;
    logic          limit_hit;
    logic          step_req;

    logic [B:0]    cnt_ext;
    logic [B:0]    ld_ext;

    // ------------------------------------------------------------------
    // Direction decode: both buttons together means no direction.
    // ------------------------------------------------------------------
    always_comb begin
        dir = DIR_NONE;
        if (inc && !dec) begin
            dir = DIR_UP;
        end else if (dec && !inc) begin
            dir = DIR_DN;
        end
    end

    assign tcnt_inc   = tcnt_q + TW'(1);
    assign tick_limit = (state_q == S_WAIT) ? HOLD_T : RPT_T;
    assign limit_hit  = tick && (tcnt_inc == tick_limit);

    // ------------------------------------------------------------------
    // State register (FSM plus counter datapath).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lastdir_q <= DIR_NONE;
            tcnt_q    <= '0;
            cnt_q     <= MIN_B;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastdir_q <= lastdir_d;
            tcnt_q    <= tcnt_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic of the repeat FSM.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lastdir_d = lastdir_q;
        tcnt_d    = tcnt_q;

        if (load || !en) begin
            // Returning to IDLE with no latched direction makes a button
            // still held afterwards look like a fresh press.
            state_d   = S_IDLE;
            lastdir_d = DIR_NONE;
            tcnt_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // A tick in the press cycle is deliberately ignored.
                    if (dir != DIR_NONE) begin
                        state_d   = S_WAIT;
                        lastdir_d = dir;
                        tcnt_d    = '0;
                    end
                end
                S_WAIT, S_REPEAT: begin
                    if (dir == DIR_NONE) begin
                        state_d   = S_IDLE;
                        lastdir_d = DIR_NONE;
                        tcnt_d    = '0;
                    end else if (dir != lastdir_q) begin
                        // Direct switch of direction restarts the hold delay.
                        state_d   = S_WAIT;
                        lastdir_d = dir;
                        tcnt_d    = '0;
                    end else if (limit_hit) begin
                        state_d = S_REPEAT;
                        tcnt_d  = '0;
                    end else if (tick) begin
                        tcnt_d = tcnt_inc;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    lastdir_d = DIR_NONE;
                    tcnt_d    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM output: one step request per cycle at most. The step direction is
    // always the current decoded dir, which equals lastdir on repeat steps.
    // ------------------------------------------------------------------
    always_comb begin
        step_req = 1'b0;
        if (!load && en && (dir != DIR_NONE)) begin
            unique case (state_q)
                S_IDLE:           step_req = 1'b1;
                S_WAIT, S_REPEAT: step_req = (dir != lastdir_q) || limit_hit;
                default:          step_req = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter datapath: clamped load, otherwise wrap/saturate stepping.
    // ------------------------------------------------------------------
    assign cnt_ext = {1'b0, cnt_q};
    assign ld_ext  = {1'b0, load_val};

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;

        if (load) begin
            if (ld_ext > MAX_W) begin
                cnt_d = MAX_B;
            end else if (ld_ext < MIN_W) begin
                cnt_d = MIN_B;
            end else begin
                cnt_d = load_val;
            end
        end else if (step_req) begin
            if (dir == DIR_UP) begin
                if (cnt_ext >= MAX_W) begin
                    if (SAT != 0) begin
                        cnt_d = MAX_B;
                    end else begin
                        cnt_d   = MIN_B;
                        carry_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + B'(1);
                end
            end else begin
                if (cnt_ext <= MIN_W) begin
                    if (SAT != 0) begin
                        cnt_d = MIN_B;
                    end else begin
                        cnt_d    = MAX_B;
                        borrow_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - B'(1);
                end
            end
        end
    end

    assign cnt    = cnt_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_modcounter_rpt.sv
// tb/tb_modcounter_rpt.sv - directed vector bench for modcounter_rpt (wrap and saturate instances)

module tb_modcounter_rpt;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       i;
        logic       d;
        logic       t;
        logic       e;
        int         exp_cnt;
        int         exp_carry;
        int         exp_borrow;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, inc, dec, tick, load;
    logic [3:0] load_val;
    logic [3:0] cnt0, cnt1;
    logic       carry0, borrow0, carry1, borrow1;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    modcounter_rpt #(
        .MIN(1), .MAX(12), .SAT(0), .HOLD_TICKS(3), .RPT_TICKS(2)
    ) u_wrap (
        .clk(clk), .rst(rst_n), .en(en), .inc(inc), .dec(dec), .tick(tick),
        .load(load), .load_val(load_val),
        .cnt(cnt0), .carry(carry0), .borrow(borrow0)
    );

    modcounter_rpt #(
        .MIN(1), .MAX(12), .SAT(1), .HOLD_TICKS(3), .RPT_TICKS(2)
    ) u_sat (
        .clk(clk), .rst(rst_n), .en(en), .inc(inc), .dec(dec), .tick(tick),
        .load(load), .load_val(load_val),
        .cnt(cnt1), .carry(carry1), .borrow(borrow1)
    );

    function automatic vec_t mk(input logic ld, input int lv, input logic i, input logic d,
                                input logic t, input logic e, input int c, input int ca,
                                input int bo);
        vec_t v;
        v.ld = ld; v.lv = 4'(lv); v.i = i; v.d = d; v.t = t; v.e = e;
        v.exp_cnt = c; v.exp_carry = ca; v.exp_borrow = bo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input int lv, input logic i, input logic d,
                         input logic t, input logic e);
        load = ld; load_val = 4'(lv); inc = i; dec = d; tick = t; en = e;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ld lv  i  d  t  e   cnt carry borrow
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 12, 0, 0));  // load max
        vecs.push_back(mk(0,  0, 1, 0, 0, 1,  1, 1, 0));  // inc wraps, carry
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,  1, 0, 0));  // carry is one cycle
        vecs.push_back(mk(0,  0, 0, 1, 0, 1, 12, 0, 1));  // dec wraps, borrow
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 12, 0, 0));
        vecs.push_back(mk(1, 15, 0, 0, 0, 1, 12, 0, 0));  // clamp high
        vecs.push_back(mk(1,  0, 0, 0, 0, 1,  1, 0, 0));  // clamp low
        vecs.push_back(mk(1,  3, 0, 0, 0, 1,  3, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0, 1,  4, 0, 0));  // press
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  4, 0, 0));  // tick 1
        vecs.push_back(mk(0,  0, 1, 0, 0, 1,  4, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  4, 0, 0));  // tick 2
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  5, 0, 0));  // tick 3: first repeat
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  5, 0, 0));  // tick 4
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  6, 0, 0));  // tick 5
        vecs.push_back(mk(0,  0, 1, 0, 0, 1,  6, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  6, 0, 0));  // tick 6
        vecs.push_back(mk(0,  0, 1, 0, 1, 1,  7, 0, 0));  // tick 7
        vecs.push_back(mk(0,  0, 0, 1, 0, 1,  6, 0, 0));  // switch to dec in REPEAT
        vecs.push_back(mk(0,  0, 0, 1, 1, 1,  6, 0, 0));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1,  6, 0, 0));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1,  5, 0, 0));  // third tick after switch
        vecs.push_back(mk(0,  0, 0, 0, 1, 1,  5, 0, 0));  // release
        vecs.push_back(mk(0,  0, 0, 0, 1, 1,  5, 0, 0));
        vecs.push_back(mk(1, 12, 1, 0, 0, 1, 12, 0, 0));  // load beats inc press
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 12, 0, 0));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt_wrap", int'(cnt0), 1);
        chk("rst_carry", int'(carry0), 0);
        chk("rst_borrow", int'(borrow0), 0);
        chk("rst_cnt_sat", int'(cnt1), 1);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_idle", int'(cnt0), 1);

        foreach (vecs[k]) begin
            drive(vecs[k].ld, int'(vecs[k].lv), vecs[k].i, vecs[k].d, vecs[k].t, vecs[k].e);
            cycle();
            chk($sformatf("vec%0d_cnt", k), int'(cnt0), vecs[k].exp_cnt);
            chk($sformatf("vec%0d_carry", k), int'(carry0), vecs[k].exp_carry);
            chk($sformatf("vec%0d_borrow", k), int'(borrow0), vecs[k].exp_borrow);
        end

        // Both buttons held with ticks: no direction, no steps.
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 1, 1, 1, 1);
            cycle();
            chk($sformatf("both_cnt%0d", n), int'(cnt0), 12);
            chk($sformatf("both_flags%0d", n), int'(carry0 | borrow0), 0);
        end
        drive(0, 0, 0, 0, 0, 1);
        cycle();

        // Asynchronous reset while WAIT is active at cnt=7.
        drive(1, 6, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 1, 0, 0, 1);
        cycle();
        chk("pre_rst_cnt", int'(cnt0), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", int'(cnt0), 1);
        chk("async_rst_carry", int'(carry0), 0);
        chk("async_rst_borrow", int'(borrow0), 0);
        inc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            drive(0, 0, 0, 0, 1, 1);
            cycle();
            chk($sformatf("after_rst_cnt%0d", n), int'(cnt0), 1);
        end

        // Saturating instance: hold inc at MAX.
        drive(1, 12, 0, 0, 0, 1);
        cycle();
        chk("sat_load", int'(cnt1), 12);
        drive(0, 0, 1, 0, 0, 1);
        cycle();
        chk("sat_press_cnt", int'(cnt1), 12);
        chk("sat_press_carry", int'(carry1), 0);
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 1, 0, 1, 1);
            cycle();
            chk($sformatf("sat_hold_cnt%0d", n), int'(cnt1), 12);
            chk($sformatf("sat_hold_carry%0d", n), int'(carry1), 0);
        end

        // Saturating at MIN on a down press.
        drive(1, 1, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 1, 0, 1);
        cycle();
        chk("sat_min_cnt", int'(cnt1), 1);
        chk("sat_min_borrow", int'(borrow1), 0);

        // en=0 during a hold stops stepping; en back with inc held is a new press.
        drive(1, 3, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 1, 0, 0, 1);
        cycle();
        chk("en_press", int'(cnt1), 4);
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 0, 1, 1);
            cycle();
        end
        chk("en_first_repeat", int'(cnt1), 5);
        for (int n = 0; n < 4; n++) begin
            drive(0, 0, 1, 0, 1, 0);
            cycle();
            chk($sformatf("en_off_cnt%0d", n), int'(cnt1), 5);
        end
        drive(0, 0, 1, 0, 0, 1);
        cycle();
        chk("en_back_step", int'(cnt1), 6);
        drive(0, 0, 0, 0, 0, 1);
        cycle();
        chk("en_release", int'(cnt1), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modcounter_rpt.md
# modcounter_rpt

Parametrised modulo up/down counter with programmable range MIN..MAX, synchronous load, wrap or saturate mode, cascade carry/borrow pulses, and press-and-hold auto-repeat. It generalises the fixed modulo counters in the alarm clock's time-setting path. It takes debounced inc/dec button levels and a slow timebase strobe, and drives hour, minute and second digit registers. Carry and borrow feed the next counter in a chain.

## Interface
- MIN, default 0: lowest count value.
- MAX, default 12: highest count value; MAX > MIN required.
- B, default $clog2(MAX+1): width of cnt and load_val.
- SAT, default 0: 0 selects wrap, 1 selects saturate at the range ends.
- HOLD_TICKS, default 8: number of tick strobes a button must be held before auto-repeat starts; must be ≥ 1.
- RPT_TICKS, default 2: number of tick strobes between auto-repeat steps; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  step enable; 0 blocks all inc/dec steps.
- inc  in  1  debounced level; high means the up button is held.
- dec  in  1  debounced level; high means the down button is held.
- tick  in  1  one-cycle timebase strobe used for hold and repeat timing.
- load  in  1  synchronous load request.
- load_val  in  B  value to load.
- cnt  out  B  current count, registered.
- carry  out  1  one-cycle pulse on an up wrap.
- borrow  out  1  one-cycle pulse on a down wrap.

## Operation
- Direction decode: dir=UP when inc&&!dec; dir=DN when dec&&!inc; otherwise dir=NONE. inc&&dec together counts as NONE.
- Priority, highest first: reset, load, step.
- Load:
  - load=1 loads load_val in the next cycle, independent of en.
  - load_val > MAX loads MAX; load_val < MIN loads MIN.
  - A load forces the FSM to IDLE, suppresses any step in that cycle, and never raises carry or borrow.
- Step UP:
  - cnt<MAX gives cnt+1.
  - cnt==MAX with SAT=0 gives MIN and carry=1.
  - cnt==MAX with SAT=1 holds MAX and carry stays 0.
- Step DN:
  - cnt>MIN gives cnt-1.
  - cnt==MIN with SAT=0 gives MAX and borrow=1.
  - cnt==MIN with SAT=1 holds MIN and borrow stays 0.
- Arithmetic: use B+1 bits internally so MAX+1 and MIN-1 cannot alias. cnt never leaves MIN..MAX.
- Repeat FSM, states IDLE, WAIT, REPEAT:
  - tcnt counts tick strobes. lastdir holds the direction latched on the last press.
  - IDLE: dir≠NONE and en → one step in dir, latch lastdir, tcnt=0, go to WAIT.
  - WAIT: on each tick, tcnt++. When tcnt reaches HOLD_TICKS, step, set tcnt=0, go to REPEAT.
  - REPEAT: on each tick, tcnt++. When tcnt reaches RPT_TICKS, step and set tcnt=0.
  - WAIT or REPEAT, dir==NONE → go to IDLE with no step.
  - WAIT or REPEAT, dir≠lastdir and dir≠NONE → treat as a new press: step in the new dir, relatch lastdir, tcnt=0, go to WAIT.
  - en=0 in any state → go to IDLE. A level still held when en returns counts as a new press.

## Timing
- Reset values: cnt=MIN, carry=0, borrow=0, FSM=IDLE, tcnt=0, lastdir=NONE.
- Press latency: dir is sampled in cycle N; cnt updates at edge N+1.
- carry and borrow are registered and high for exactly the cycle in which cnt shows the wrapped value.
- Repeat timing:
  - The first repeat step comes on the edge after the HOLD_TICKS-th tick following the press.
  - Later steps come on the edge after every RPT_TICKS-th tick.
  - A tick in the same cycle as the press is not counted.
- At most one step per cycle. tick and a press edge in the same cycle produce one step.
- Asserting rst during WAIT or REPEAT clears everything immediately. No step is produced after rst is released unless a new press is detected.
- load and a tick in the same cycle: the load wins and the FSM enters IDLE.

## Test plan
Parameters for all scenarios: MIN=1, MAX=12, HOLD_TICKS=3, RPT_TICKS=2, SAT=0.
- Reset and initial state: assert rst=0 mid-count at cnt=7 → cnt=1 asynchronously, carry=borrow=0, and no step after release while inc stays low.
- Single press and wrap: load 12, then a single inc press released before any tick → cnt=1 with a one-cycle carry pulse. A dec press from cnt=1 → cnt=12 with a one-cycle borrow.
- Auto-repeat: hold inc from cnt=3 and issue 7 ticks → cnt=4 at the press, 5 after tick 3, 6 after tick 5, 7 after tick 7. Release → no further steps.
- Simultaneous and switched inputs: inc&&dec together for 10 ticks → cnt unchanged. Switching inc→dec directly while in REPEAT → immediate −1 step, then WAIT restarts with 3 ticks.
- Load clamping and priority:
  - load_val=15 → cnt=12.
  - load_val=0 → cnt=1.
  - load together with an inc press → load value taken, no step, no carry.
- Saturate mode (SAT=1):
  - Hold inc at cnt=12 for 10 ticks → cnt stays 12, carry never asserts.
  - en=0 during a hold → steps stop; raising en again while inc is still held → one immediate step.
